// File: rtl/jb_hs_ram_arbiter.sv
// -----------------------------------------------------------------------------
// jb_hs_ram_arbiter
//
// Shares the Jailbreak work-RAM port between the main CPU and the hiscore
// engine. When hiscore asks for the bus, the CPU is paused (cpu_hold) and a
// few of its clock-enable strobes are allowed to go by so any cycle already
// in progress can finish. The RAM port is then handed to hiscore, which does
// single-byte read/write handshakes. Dropping the hiscore pause returns the
// port to the CPU.
//
// Optional feature macro: JB_HSARB_WATCHDOG_EN
//   When defined, an idle watchdog in OWN forces the port back to the CPU
//   after WDT_CYCLES cycles without a hiscore access. The arbiter then stays
//   idle until hs_pause has been seen low at least once.
//
// Parameters
//   AW          RAM address width
//   DW          RAM data width
//   DRAIN       cpu_cen strobes to let pass after cpu_hold rises
//   WDT_CYCLES  idle OWN cycles before forced release (watchdog build only)
//
// Ports
//   clk_49m              system clock
//   reset                synchronous reset, active-high
//   cpu_cen/cs/we        CPU clock enable, RAM select, write strobe
//   cpu_addr/din/dout    CPU address, write data, read data (= ram_dout)
//   hs_pause             hiscore bus-ownership request (level)
//   hs_req/we            hiscore access strobe (1 cycle), 1 = write
//   hs_addr/din/dout     hiscore address, write data, registered read data
//   hs_ack               access-done pulse, 2 cycles after hs_req
//   hs_grant             hiscore currently owns the RAM port
//   cpu_hold             CPU pause request
//   ram_addr/din/we      to the single-port RAM (read latency 1)
//   ram_dout             RAM read data
// -----------------------------------------------------------------------------
module jb_hs_ram_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 8,
  parameter int DRAIN      = 2,
  parameter int WDT_CYCLES = 4096
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          cpu_cen,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic          hs_pause,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_din,
  output logic [DW-1:0] hs_dout,
  output logic          hs_ack,
  output logic          hs_grant,
  output logic          cpu_hold,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRAIN   = 3'd1;
  localparam logic [2:0] S_OWN     = 3'd2;
  localparam logic [2:0] S_ACC     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam int             DCW        = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN - 1);

  logic [2:0]     state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           cpu_hold_q, cpu_hold_d;
  logic           hs_grant_q, hs_grant_d;
  logic           hs_ack_q, hs_ack_d;
  logic [DW-1:0]  hs_dout_q, hs_dout_d;

  // Access captured on hs_req; data path only, so not reset.
  logic [AW-1:0]  acc_addr_q, acc_addr_d;
  logic [DW-1:0]  acc_din_q, acc_din_d;
  logic           acc_we_q, acc_we_d;

  logic           pause_ok;
  logic           wdt_fire;

`ifdef JB_HSARB_WATCHDOG_EN
  localparam logic [12:0] WDT_LAST = 13'(WDT_CYCLES - 1);

  logic [12:0] wdt_q, wdt_d;
  logic        wdt_block_q, wdt_block_d;
`endif

  assign cpu_dout = ram_dout;
  assign hs_dout  = hs_dout_q;
  assign hs_ack   = hs_ack_q;
  assign hs_grant = hs_grant_q;
  assign cpu_hold = cpu_hold_q;

  // RAM port mux. While hiscore owns the port the CPU write path is cut off
  // entirely. In OWN the live hiscore address is presented so a read issued
  // on hs_req has its data back one cycle later, in time to be registered
  // for the ack. Reset kills any write combinationally.
  always_comb begin
    if (hs_grant_q) begin
      ram_addr = (state_q == S_ACC) ? acc_addr_q : hs_addr;
      ram_din  = (state_q == S_ACC) ? acc_din_q  : hs_din;
      ram_we   = (state_q == S_ACC) & acc_we_q & ~reset;
    end else begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_cs & cpu_we & cpu_cen & ~reset;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    cpu_hold_d  = cpu_hold_q;
    hs_grant_d  = hs_grant_q;
    hs_ack_d    = 1'b0;
    hs_dout_d   = hs_dout_q;
    acc_addr_d  = acc_addr_q;
    acc_din_d   = acc_din_q;
    acc_we_d    = acc_we_q;
    pause_ok    = hs_pause;
    wdt_fire    = 1'b0;

`ifdef JB_HSARB_WATCHDOG_EN
    // After a forced release, a new request is honoured only once hs_pause
    // has been low for at least one cycle.
    wdt_block_d = wdt_block_q & hs_pause;
    pause_ok    = hs_pause & ~wdt_block_q;
    wdt_fire    = (state_q == S_OWN) & ~hs_req & (wdt_q == WDT_LAST);
    case (state_q)
      S_OWN:   wdt_d = hs_req ? 13'd0 : wdt_q + 13'd1;
      S_ACC:   wdt_d = wdt_q;
      default: wdt_d = 13'd0;
    endcase
    if (wdt_fire && hs_pause) begin
      wdt_block_d = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        drain_cnt_d = '0;
        if (pause_ok) begin
          state_d    = S_DRAIN;
          cpu_hold_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!hs_pause) begin
          state_d     = S_IDLE;
          cpu_hold_d  = 1'b0;
          drain_cnt_d = '0;
        end else if (cpu_cen) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d     = S_OWN;
            hs_grant_d  = 1'b1;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      S_OWN: begin
        if (!hs_pause || wdt_fire) begin
          state_d    = S_RELEASE;
          hs_grant_d = 1'b0;
        end else if (hs_req) begin
          state_d    = S_ACC;
          acc_addr_d = hs_addr;
          acc_din_d  = hs_din;
          acc_we_d   = hs_we;
        end
      end
      S_ACC: begin
        // Single cycle: the write strobes here, or the read data launched
        // from OWN is captured. Either way the ack lands on the next cycle.
        state_d  = S_OWN;
        hs_ack_d = 1'b1;
        if (!acc_we_q) begin
          hs_dout_d = ram_dout;
        end
      end
      S_RELEASE: begin
        state_d    = S_IDLE;
        cpu_hold_d = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        cpu_hold_d = 1'b0;
        hs_grant_d = 1'b0;
      end
    endcase
  end

  // Control state
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      cpu_hold_q  <= 1'b0;
      hs_grant_q  <= 1'b0;
      hs_ack_q    <= 1'b0;
      hs_dout_q   <= '0;
`ifdef JB_HSARB_WATCHDOG_EN
      wdt_q       <= 13'd0;
      wdt_block_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cpu_hold_q  <= cpu_hold_d;
      hs_grant_q  <= hs_grant_d;
      hs_ack_q    <= hs_ack_d;
      hs_dout_q   <= hs_dout_d;
`ifdef JB_HSARB_WATCHDOG_EN
      wdt_q       <= wdt_d;
      wdt_block_q <= wdt_block_d;
`endif
    end
  end

  // Captured access
  always_ff @(posedge clk_49m) begin
    acc_addr_q <= acc_addr_d;
    acc_din_q  <= acc_din_d;
    acc_we_q   <= acc_we_d;
  end

endmodule
